// File: rtl/imm_pkg.sv
// Shared encodings for the registered immediate generator: major opcode
// values (instr[6:2]), the immediate format code and the skid buffer states.
package imm_pkg;

    localparam logic [4:0] OPC_LOAD    = 5'b00000;
    localparam logic [4:0] OPC_OPIMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_LUI     = 5'b01101;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_JALR    = 5'b11001;
    localparam logic [4:0] OPC_JAL     = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZIMM  = 3'd7
    } imm_type_t;

    // EMPTY: nothing held; ONE: output register valid; FULL: skid also valid
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for RV32/RV64 base instructions.
// Produces the XLEN-wide immediate, its format code and an illegal flag for
// encodings whose low two bits are not 2'b11 (those decode as NONE/0).
module imm_decode import imm_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_t       imm_type,
    output logic            illegal
);

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic       shift_op;
    logic [5:0] shamt;

    assign opcode   = instr[6:2];
    assign funct3   = instr[14:12];
    // SLLI / SRLI / SRAI share funct3 x01
    assign shift_op = (funct3[1:0] == 2'b01);
    assign illegal  = (instr[1:0] != 2'b11);

    // Select format by major opcode and build the sign/zero-extended value
    always_comb begin
        imm      = '0;
        imm_type = IMM_NONE;
        shamt    = instr[25:20];
        if (XLEN == 32) begin
            shamt[5] = 1'b0;
        end
        if (!illegal) begin
            case (opcode)
                OPC_LOAD, OPC_JALR: begin
                    imm_type = IMM_I;
                    imm      = XLEN'($signed(instr[31:20]));
                end
                OPC_OPIMM: begin
                    if (shift_op) begin
                        imm_type = IMM_SHAMT;
                        imm      = XLEN'(shamt);
                    end else begin
                        imm_type = IMM_I;
                        imm      = XLEN'($signed(instr[31:20]));
                    end
                end
                OPC_OPIMM32: begin
                    // word ops only exist on RV64; on RV32 this is reserved
                    if (XLEN == 64) begin
                        if (shift_op) begin
                            imm_type = IMM_SHAMT;
                            imm      = XLEN'(instr[24:20]);
                        end else begin
                            imm_type = IMM_I;
                            imm      = XLEN'($signed(instr[31:20]));
                        end
                    end
                end
                OPC_STORE: begin
                    imm_type = IMM_S;
                    imm      = XLEN'($signed({instr[31:25], instr[11:7]}));
                end
                OPC_BRANCH: begin
                    imm_type = IMM_B;
                    imm      = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                              instr[11:8], 1'b0}));
                end
                OPC_LUI, OPC_AUIPC: begin
                    imm_type = IMM_U;
                    imm      = XLEN'($signed({instr[31:12], 12'b0}));
                end
                OPC_JAL: begin
                    imm_type = IMM_J;
                    imm      = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                              instr[30:21], 1'b0}));
                end
                OPC_SYSTEM: begin
                    if (funct3[2]) begin
                        imm_type = IMM_ZIMM;
                        imm      = XLEN'(instr[19:15]);
                    end else begin
                        imm_type = IMM_I;
                        imm      = XLEN'($signed(instr[31:20]));
                    end
                end
                default: begin
                    imm_type = IMM_NONE;
                    imm      = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the ID stage. Decodes each accepted
// instruction into an output register, with a one-entry skid so that
// in_ready is a pure register output and never waits on out_ready.
module imm_gen_pipe import imm_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    imm_type_t        dec_type;
    logic             dec_illegal;

    skid_state_t      state, state_next;
    logic             in_ready_r;
    logic             accept, drain;
    logic             load_out_new, load_out_skid, load_skid;

    logic [XLEN-1:0]  imm_p1, skid_imm_p1;
    imm_type_t        type_p1, skid_type_p1;
    logic             illegal_p1, skid_illegal_p1;
    logic [TAG_W-1:0] tag_p1, skid_tag_p1;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr    (in_instr),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    // An entry offered during flush is never taken, whatever in_ready says
    assign accept      = in_valid && in_ready_r && !flush;
    assign drain       = (state != SKID_EMPTY) && out_ready;

    assign in_ready    = in_ready_r;
    assign out_valid   = (state != SKID_EMPTY);
    assign out_imm     = imm_p1;
    assign out_type    = type_p1;
    assign out_illegal = illegal_p1;
    assign out_tag     = tag_p1;

    // Occupancy transitions and register load selects
    always_comb begin
        state_next    = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (accept) begin
                    load_out_new = 1'b1;
                    state_next   = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && out_ready) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = SKID_FULL;
                end else if (out_ready) begin
                    state_next = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_ready) begin
                    load_out_skid = 1'b1;
                    state_next    = SKID_ONE;
                end
            end
            default: state_next = SKID_EMPTY;
        endcase
        if (flush) begin
            state_next = SKID_EMPTY;
        end
    end

    // Control state; in_ready is registered from the next occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SKID_EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_r <= (state_next != SKID_FULL);
        end
    end

    // Stage 1: output register, fed from decode or from the skid entry
    always_ff @(posedge clk) begin
        if (load_out_skid) begin
            imm_p1     <= skid_imm_p1;
            type_p1    <= skid_type_p1;
            illegal_p1 <= skid_illegal_p1;
            tag_p1     <= skid_tag_p1;
        end else if (load_out_new) begin
            imm_p1     <= dec_imm;
            type_p1    <= dec_type;
            illegal_p1 <= dec_illegal;
            tag_p1     <= in_tag;
        end
    end

    // Skid entry captures a decode that arrives while the output is held
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_imm_p1     <= dec_imm;
            skid_type_p1    <= dec_type;
            skid_illegal_p1 <= dec_illegal;
            skid_tag_p1     <= in_tag;
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the ID stage; successor to the combinational extension unit.
- Decodes I/S/B/U/J immediates, shift amounts and CSR zimm for XLEN 32 or 64, and reports the immediate format.
- Carries a tag (PC) alongside and sits between IF/ID and the ID/EX register.
- valid/ready handshake in both directions, 2-entry skid buffer, flush for branch redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
TAG_W, 32, width of sideband tag carried with each instruction (normally PC)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  instruction offered
in_ready  output  1  block can accept this cycle
in_instr  input  32  raw instruction
in_tag  input  TAG_W  sideband tag
flush  input  1  discard all held and incoming entries
out_valid  output  1  immediate available
out_ready  input  1  consumer accepts this cycle
out_imm  output  XLEN  extended immediate
out_type  output  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, ZIMM=7
out_illegal  output  1  instr[1:0] != 2'b11
out_tag  output  TAG_W  tag of the entry on out_*

Behaviour:
- Reset state: out_valid=0, in_ready=1, skid empty. Reset is synchronous only, and rst overrides flush and handshakes in the same cycle.
- Decode is combinational on in_instr into imm_decode, then registered on accept. Latency is 1 cycle from accept to out_valid.
- Decode keys on instr[6:2]. Reserved patterns, illegal instructions and R-type give imm=0 and type NONE.
  - LOAD 00000, JALR 11001, OP-IMM 00100: I-type, sign-extend instr[31:20] to XLEN.
  - OP-IMM with funct3 001/101: SHAMT, zero-extended. XLEN=32 uses instr[24:20]; XLEN=64 uses instr[25:20].
  - OP-IMM-32 00110, XLEN=64 only: I-type, or SHAMT from instr[24:20] for funct3 001/101. With XLEN=32 it is NONE.
  - STORE 01000: S-type, {instr[31:25], instr[11:7]} sign-extended.
  - BRANCH 11000: B-type, {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
  - LUI 01101 and AUIPC 00101: U-type, {instr[31:12], 12'b0} sign-extended to XLEN.
  - JAL 11011: J-type, {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
  - SYSTEM 11100: funct3[2]=1 gives ZIMM, instr[19:15] zero-extended. Otherwise I-type (CSR address sign-extended).
  - out_illegal=1 forces type NONE and imm 0, but the entry still flows.
- Handshake:
  - Transfer occurs when valid&&ready on either side.
  - in_ready is a registered signal equal to !skid_full. It never depends combinationally on out_ready.
  - An accept while the output register is empty, or is draining this cycle, loads the output register.
  - An accept while the output register is held (out_valid && !out_ready) loads the skid.
  - When the output register drains and the skid is full, the skid moves to the output register in the same cycle and the skid clears.
  - Ordering is strictly FIFO. No entry is dropped or duplicated.
  - out_* stay stable while out_valid && !out_ready.
- States: EMPTY (out_valid=0), ONE (out_valid=1, skid empty), FULL (skid full, in_ready=0).
  - EMPTY→ONE on accept.
  - ONE→FULL on accept && !out_ready.
  - ONE→EMPTY on drain && !accept.
  - FULL→ONE on drain.
  - Simultaneous accept and drain in ONE stays in ONE with the new entry.
- Flush:
  - The next cycle is EMPTY with in_ready=1.
  - An entry offered in the flush cycle is not accepted, and in_ready is ignored for that cycle.
  - A drain coinciding with flush still counts as consumed by the downstream stage.
- Tag: carried unchanged, and is not reset-cleared (don't-care while out_valid=0). Data registers need no reset.

Decomposition:
- Package imm_pkg:
  - opcode[6:2] constants (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM).
  - imm_type_t 3-bit enum.
  - Skid state enum.
- Sub-module imm_decode, parametrised by XLEN. It is purely combinational: instr → imm, type, illegal.
- imm_gen_pipe holds only the skid/handshake logic and registers.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_type=I.
- beq x0,x0,-4 (0xFE000EE3) → out_imm=0xFFFFFFFC, out_type=B. XLEN=64 run → 0xFFFFFFFFFFFFFFFC.
- lui x5,0x12345 (0x123452B7) and auipc x5,0x12345 (0x12345297) back-to-back → both give 0x12345000, type U, one per cycle.
- srai x1,x1,5 (0x4050D093) → out_imm=5, type SHAMT. csrrwi x0,0x300,31 (0x300FD073) → out_imm=31, type ZIMM.
- Stream 4 instrs, out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepts.
  - After out_ready rises, all 4 emerge in order with tags 0x0, 0x4, 0x8, 0xC.
  - No gaps while both sides stay valid/ready.
- Reach FULL, then pulse flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed input never appears. Repeat with rst instead of flush → same result.
